// File: rtl/mips_pkg.sv
// Shared definitions for the address-generation datapath: word width, a
// constant-friendly clog2 and the tagged adder result record.
package mips_pkg;

    localparam int WORD_W   = 32;
    // Widest requester index the result record can carry (up to 8 requesters).
    localparam int ID_MAX_W = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef struct packed {
        logic [WORD_W-1:0]   sum;
        logic                carry;
        logic                ovf;
        logic [ID_MAX_W-1:0] id;
    } add_result_t;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr
// wins, reported as a one-hot grant plus its encoded index.
import mips_pkg::*;

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rotated;
    logic [ID_W-1:0]      offset;
    logic [ID_W:0]        idx_sum;
    logic                 found;

    // Rotate so that bit 0 of 'rotated' is the requester at ptr.
    assign req_dbl = {req, req} >> ptr;
    assign rotated = req_dbl[NUM_REQ-1:0];

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = ID_W'(k);
            end
        end
    end

    assign idx_sum   = {1'b0, ptr} + {1'b0, offset};
    assign grant_idx = ID_W'((idx_sum >= (ID_W+1)'(NUM_REQ)) ?
                             idx_sum - (ID_W+1)'(NUM_REQ) : idx_sum);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = enable && found && (grant_idx == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/adder_arbiter.sv
// Shares one WIDTH+1-bit adder among NUM_REQ address generators with
// round-robin grants and a single tagged, back-pressurable result register.
import mips_pkg::*;

module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WORD_W,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     rsp_ovf,
    output logic [ID_W-1:0]          rsp_id
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]         state_reg, state_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;
    add_result_t        res_reg, res_next;

    logic               slot_free;
    logic               grant_valid;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH:0]     add_full;
    logic               add_ovf;
    logic               unused_res;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A consume in the same cycle frees the slot, so a full register never
    // costs a bubble while the consumer keeps taking results.
    assign slot_free = (state_reg == ST_EMPTY) || rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .enable    (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_valid = |grant;
    assign req_ready   = grant;

    assign op_a     = a_arr[grant_idx];
    assign op_b     = b_arr[grant_idx];
    assign add_full = {1'b0, op_a} + {1'b0, op_b};
    assign add_ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (add_full[WIDTH-1] != op_a[WIDTH-1]);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        res_next   = res_reg;
        if (grant_valid) begin
            state_next     = ST_FULL;
            ptr_next       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            res_next.sum   = WORD_W'(add_full[WIDTH-1:0]);
            res_next.carry = add_full[WIDTH];
            res_next.ovf   = add_ovf;
            res_next.id    = ID_MAX_W'(grant_idx);
        end else if (rsp_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            ptr_reg   <= '0;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            res_reg   <= res_next;
        end
    end

    assign rsp_valid = (state_reg == ST_FULL);
    assign rsp_sum   = res_reg.sum[WIDTH-1:0];
    assign rsp_carry = res_reg.carry;
    assign rsp_ovf   = res_reg.ovf;
    assign rsp_id    = res_reg.id[ID_W-1:0];

    // The record is sized for the widest configuration; spare bits are ignored.
    assign unused_res = &{1'b0, res_reg};

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a reference arbiter/adder model predicts
// grants and results, and directed checks pin the documented corner vectors.
module tb_adder_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;
    logic           rsp_ovf;
    logic [1:0]     rsp_id;

    always #5 clk = ~clk;

    adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           id;
    } exp_t;

    exp_t  sb [$];
    int    id_log [$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    m_full   = 1'b0;
    int    m_ptr    = 0;
    int    last_grant = -1;
    logic [W-1:0] held_sum;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
    endtask

    // One clock: predict and compare at the falling edge, then advance the model.
    task automatic cycle();
        int           g;
        int           idx;
        logic [N-1:0] exp_ready;
        logic [W:0]   full;
        logic [W-1:0] a, b;
        longint       ssum;
        exp_t         e, h;
        @(negedge clk);
        g = -1;
        exp_ready = '0;
        if (!m_full || rsp_ready) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("rsp_valid", rsp_valid, m_full);
        if (m_full) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: got result id=%0d expected none", rsp_id);
            end else begin
                h = sb[0];
                check_eq("rsp_sum", rsp_sum, h.sum);
                check_eq("rsp_carry", rsp_carry, h.carry);
                check_eq("rsp_ovf", rsp_ovf, h.ovf);
                check_eq("rsp_id", rsp_id, h.id);
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    id_log.push_back(int'(rsp_id));
                    $display("result id=%0d sum=%08h carry=%0b ovf=%0b", rsp_id, rsp_sum, rsp_carry, rsp_ovf);
                end
            end
        end
        if (g >= 0) begin
            a = req_a[g*W +: W];
            b = req_b[g*W +: W];
            full = {1'b0, a} + {1'b0, b};
            ssum = longint'($signed(a)) + longint'($signed(b));
            e.sum   = full[W-1:0];
            e.carry = full[W];
            e.ovf   = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
            e.id    = g;
            sb.push_back(e);
            m_ptr = (g + 1) % N;
        end
        last_grant = g;
        m_full = (g >= 0) ? 1'b1 : (rsp_ready ? 1'b0 : m_full);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rsp_sum", rsp_sum, 0);
        check_eq("reset_rsp_carry", rsp_carry, 0);
        check_eq("reset_rsp_ovf", rsp_ovf, 0);
        check_eq("reset_rsp_id", rsp_id, 0);
        check_eq("reset_req_ready", req_ready, 0);
        rst_n = 1'b1;

        // Single request, then wrap and overflow vectors on requester 0.
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 32'h0000_0004, 32'h0040_0000);
        cycle();
        req_valid = '0;
        check_eq("single_valid", rsp_valid, 1);
        check_eq("single_sum", rsp_sum, 32'h0040_0004);
        check_eq("single_carry", rsp_carry, 0);
        check_eq("single_ovf", rsp_ovf, 0);
        check_eq("single_id", rsp_id, 0);

        req_valid = 4'b0001;
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0001);
        cycle();
        req_valid = '0;
        check_eq("wrap_sum", rsp_sum, 32'h0000_0000);
        check_eq("wrap_carry", rsp_carry, 1);
        check_eq("wrap_ovf", rsp_ovf, 0);

        req_valid = 4'b0001;
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001);
        cycle();
        req_valid = '0;
        check_eq("ovf_sum", rsp_sum, 32'h8000_0000);
        check_eq("ovf_carry", rsp_carry, 0);
        check_eq("ovf_ovf", rsp_ovf, 1);
        cycle();

        // Fairness from a fresh ptr=0 with every requester continuously valid.
        rst_n = 1'b0;
        m_full = 1'b0;
        m_ptr = 0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        id_log.delete();
        for (int r = 0; r < N; r++) set_req(r, $urandom, $urandom);
        req_valid = 4'b1111;
        repeat (8) begin
            cycle();
            if (last_grant >= 0) set_req(last_grant, pick_operand(), pick_operand());
        end
        req_valid = '0;
        cycle();
        check_eq("fair_count", id_log.size(), 8);
        for (int k = 0; k < 8 && k < id_log.size(); k++)
            check_eq($sformatf("fair_id%0d", k), id_log[k], k % 4);

        // Backpressure: result held stable, requester 2 waits, then back-to-back.
        req_valid = 4'b0010;
        set_req(1, 32'h1234_5678, 32'h1111_1111);
        cycle();
        held_sum = 32'h2345_6789;
        req_valid = 4'b0100;
        set_req(2, 32'h8000_0000, 32'h8000_0000);
        rsp_ready = 1'b0;
        repeat (3) begin
            cycle();
            check_eq("bp_hold_sum", rsp_sum, held_sum);
            check_eq("bp_hold_id", rsp_id, 1);
        end
        rsp_ready = 1'b1;
        cycle();
        req_valid = '0;
        check_eq("bp_release_id", rsp_id, 2);
        check_eq("bp_release_sum", rsp_sum, 32'h0000_0000);
        check_eq("bp_release_carry", rsp_carry, 1);
        check_eq("bp_release_ovf", rsp_ovf, 1);
        cycle();

        // Reset while holding a result from requester 3.
        req_valid = 4'b1000;
        set_req(3, 32'h0000_0010, 32'h0000_0020);
        rsp_ready = 1'b0;
        cycle();
        req_valid = '0;
        check_eq("mid_full_id", rsp_id, 3);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", rsp_valid, 0);
        check_eq("mid_rst_sum", rsp_sum, 0);
        m_full = 1'b0;
        m_ptr = 0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        cycle();
        check_eq("post_rst_id", rsp_id, 0);
        req_valid = '0;
        cycle();

        // Random traffic with requesters holding until accepted.
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    set_req(r, pick_operand(), pick_operand());
                    req_valid[r] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) cycle();
        check_eq("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
